// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding, default parameters and address check for the data memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int          DEPTH_WORDS_DEF = 256;
    localparam int          WAIT_CYCLES_DEF = 2;
    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h64;

    // Misaligned byte address or word index beyond the storage array.
    function automatic logic addr_bad(input logic [31:0] addr, input int depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= $unsigned(depth_words));
    endfunction

endpackage

// File: rtl/word_ram.sv
// rtl/word_ram.sv - single-port 32-bit word storage with byte enables, synchronous write and combinational read
module word_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data memory responder with a sticky tohost completion mailbox
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        tohost_valid,
    output logic [31:0] tohost_data
);

    localparam int         ADDR_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic        ready_en;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_be;
    logic        accept, enter_resp, commit;
    logic        cur_we, cur_err;
    logic [31:0] cur_addr, cur_wdata, ram_rdata;
    logic [3:0]  cur_be;

    assign req_ready = (state == ST_IDLE) && ready_en;
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;

    // With zero wait states RESP is entered on the accept edge itself, before the latch holds the request.
    assign cur_we    = (state == ST_IDLE) ? req_we    : lat_we;
    assign cur_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
    assign cur_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
    assign cur_be    = (state == ST_IDLE) ? req_be    : lat_be;
    assign cur_err   = addr_bad(cur_addr, DEPTH_WORDS);
    assign commit    = enter_resp && cur_we && !cur_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt     <= 4'd0;
            ready_en     <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
            tohost_valid <= 1'b0;
            tohost_data  <= 32'd0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_err   <= cur_err;
                rsp_rdata <= (cur_we || cur_err) ? 32'd0 : ram_rdata;
            end else if (state == ST_RESP && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
            if (commit && cur_addr == TOHOST_ADDR && cur_be == 4'hF) begin
                tohost_valid <= 1'b1;
                tohost_data  <= cur_wdata;
            end
        end
    end

    word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (commit),
        .addr (cur_addr[ADDR_W+1:2]),
        .wdata(cur_wdata),
        .be   (cur_be),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        req_ready, rsp_valid, rsp_err, tohost_valid;
    logic [31:0] rsp_rdata, tohost_data;

    logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b0;
    logic [31:0] z_req_addr = 32'd0, z_req_wdata = 32'd0;
    logic [3:0]  z_req_be = 4'd0;
    logic        z_req_ready, z_rsp_valid, z_rsp_err, z_tohost_valid;
    logic [31:0] z_rsp_rdata, z_tohost_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_responder u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .tohost_valid(tohost_valid), .tohost_data(tohost_data)
    );

    data_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
        .rsp_err(z_rsp_err), .tohost_valid(z_tohost_valid), .tohost_data(z_tohost_data)
    );

    // Present one request, wait for acceptance and then for rsp_valid; returns wait cycles seen.
    task automatic issue_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output int lat);
        int k;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout addr=%h got=0 exp=1", addr);
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout addr=%h got=0 exp=1", addr);
        end
    endtask

    task automatic finish_rsp;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic err);
        int lat;
        issue_req(1'b1, addr, wdata, be, lat);
        err = rsp_err;
        finish_rsp();
    endtask

    task automatic do_load(input logic [31:0] addr, output logic [31:0] rdata, output logic err);
        int lat;
        issue_req(1'b0, addr, 32'd0, 4'hF, lat);
        rdata = rsp_rdata;
        err   = rsp_err;
        finish_rsp();
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        #1;
        checks += 6;
        if (req_ready !== 1'b0)    begin errors++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        if (rsp_valid !== 1'b0)    begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        if (rsp_rdata !== 32'd0)   begin errors++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
        if (rsp_err !== 1'b0)      begin errors++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
        if (tohost_valid !== 1'b0) begin errors++; $display("FAIL rst_tohost_valid got=%b exp=0", tohost_valid); end
        if (tohost_data !== 32'd0) begin errors++; $display("FAIL rst_tohost_data got=%h exp=0", tohost_data); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_hold_req_ready got=%b exp=0", req_ready); end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_release_req_ready got=%b exp=0", req_ready); end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_first_edge_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_tohost;
        int lat;
        issue_req(1'b1, 32'h64, 32'd7, 4'hF, lat);
        checks += 3;
        if (lat !== 2)           begin errors++; $display("FAIL tohost_latency got=%0d exp=2", lat); end
        if (rsp_err !== 1'b0)    begin errors++; $display("FAIL tohost_rsp_err got=%b exp=0", rsp_err); end
        if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL tohost_rsp_rdata got=%h exp=0", rsp_rdata); end
        finish_rsp();
        @(negedge clk);
        checks += 3;
        if (tohost_valid !== 1'b1) begin errors++; $display("FAIL tohost_valid got=%b exp=1", tohost_valid); end
        if (tohost_data !== 32'd7) begin errors++; $display("FAIL tohost_data got=%h exp=7", tohost_data); end
        if (rsp_valid !== 1'b0)    begin errors++; $display("FAIL tohost_rsp_exit got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_byte_enables;
        logic [31:0] rd;
        logic        e;
        do_store(32'h10, 32'hAABBCCDD, 4'hF, e);
        do_store(32'h10, 32'h00001100, 4'b0010, e);
        do_store(32'h10, 32'hFFFFFFFF, 4'b0000, e);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL be0_err got=%b exp=0", e); end
        do_load(32'h10, rd, e);
        checks += 2;
        if (rd !== 32'hAABB11DD) begin errors++; $display("FAIL be_merge got=%h exp=aabb11dd", rd); end
        if (e !== 1'b0)          begin errors++; $display("FAIL be_load_err got=%b exp=0", e); end
        do_store(32'h64, 32'h12345655, 4'b0001, e);
        do_load(32'h64, rd, e);
        checks += 2;
        if (rd !== 32'h00000055)   begin errors++; $display("FAIL tohost_partial_store got=%h exp=00000055", rd); end
        if (tohost_data !== 32'd7) begin errors++; $display("FAIL tohost_partial_data got=%h exp=7", tohost_data); end
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic        e;
        do_store(32'h0, 32'h12345678, 4'hF, e);
        do_load(32'h13, rd, e);
        checks += 2;
        if (e !== 1'b1)      begin errors++; $display("FAIL err_misaligned got=%b exp=1", e); end
        if (rd !== 32'd0)    begin errors++; $display("FAIL err_misaligned_rdata got=%h exp=0", rd); end
        do_load(32'h400, rd, e);
        checks += 2;
        if (e !== 1'b1)      begin errors++; $display("FAIL err_range got=%b exp=1", e); end
        if (rd !== 32'd0)    begin errors++; $display("FAIL err_range_rdata got=%h exp=0", rd); end
        do_store(32'h11, 32'h0, 4'hF, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL err_store_misaligned got=%b exp=1", e); end
        do_store(32'h400, 32'hDEADBEEF, 4'hF, e);
        do_store(32'h464, 32'h99, 4'hF, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL err_store_range got=%b exp=1", e); end
        do_load(32'h10, rd, e);
        checks++;
        if (rd !== 32'hAABB11DD) begin errors++; $display("FAIL err_no_write_0x10 got=%h exp=aabb11dd", rd); end
        do_load(32'h0, rd, e);
        checks++;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL err_no_write_0x0 got=%h exp=12345678", rd); end
        checks++;
        if (tohost_data !== 32'd7) begin errors++; $display("FAIL err_no_tohost got=%h exp=7", tohost_data); end
        do_store(32'h3FC, 32'hCAFEF00D, 4'hF, e);
        do_load(32'h3FC, rd, e);
        checks += 2;
        if (e !== 1'b0)          begin errors++; $display("FAIL last_word_err got=%b exp=0", e); end
        if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL last_word_data got=%h exp=cafef00d", rd); end
    endtask

    task automatic test_hold;
        int lat;
        issue_req(1'b0, 32'h10, 32'd0, 4'hF, lat);
        for (int i = 0; i < 5; i++) begin
            checks += 3;
            if (rsp_valid !== 1'b1)        begin errors++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, rsp_valid); end
            if (rsp_rdata !== 32'hAABB11DD) begin errors++; $display("FAIL hold_rdata cyc=%0d got=%h exp=aabb11dd", i, rsp_rdata); end
            if (req_ready !== 1'b0)        begin errors++; $display("FAIL hold_req_ready cyc=%0d got=%b exp=0", i, req_ready); end
            @(negedge clk);
        end
        finish_rsp();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_exit got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic        e;
        int          k;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h11112222; req_be = 4'hF;
        @(posedge clk);
        #1 req_addr = 32'h24; req_wdata = 32'h33334444;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready got=%b exp=0", req_ready); end
        k = 0;
        while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready got=%b exp=1", req_ready); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_rsp got=%b exp=1", rsp_valid); end
        finish_rsp();
        do_load(32'h20, rd, e);
        checks++;
        if (rd !== 32'h11112222) begin errors++; $display("FAIL b2b_latched_data got=%h exp=11112222", rd); end
        do_load(32'h24, rd, e);
        checks++;
        if (rd !== 32'h33334444) begin errors++; $display("FAIL b2b_second_data got=%h exp=33334444", rd); end
    endtask

    task automatic test_reset_midflight;
        int          lat;
        logic [31:0] rd;
        logic        e;
        issue_req(1'b0, 32'h10, 32'd0, 4'hF, lat);
        #1 reset = 1'b0;
        #1;
        checks += 3;
        if (rsp_valid !== 1'b0)  begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", rsp_valid); end
        if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_resp_rdata got=%h exp=0", rsp_rdata); end
        if (req_ready !== 1'b0)  begin errors++; $display("FAIL rst_resp_ready got=%b exp=0", req_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h64; req_wdata = 32'hDEAD0001; req_be = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_state got=%b exp=0", rsp_valid); end
        reset = 1'b0;
        #1;
        checks += 2;
        if (tohost_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_tohost_valid got=%b exp=0", tohost_valid); end
        if (tohost_data !== 32'd0) begin errors++; $display("FAIL rst_wait_tohost_data got=%h exp=0", tohost_data); end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 2;
        if (tohost_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_no_commit got=%b exp=0", tohost_valid); end
        if (rsp_valid !== 1'b0)    begin errors++; $display("FAIL rst_wait_dropped got=%b exp=0", rsp_valid); end
        do_load(32'h64, rd, e);
        checks++;
        if (rd !== 32'h00000055) begin errors++; $display("FAIL rst_wait_mem got=%h exp=00000055", rd); end
    endtask

    task automatic test_wait0;
        @(negedge clk);
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h64; z_req_wdata = 32'd9; z_req_be = 4'hF;
        @(posedge clk);
        #1 z_req_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (z_rsp_valid !== 1'b1) begin errors++; $display("FAIL w0_store_latency got=%b exp=1", z_rsp_valid); end
        if (z_rsp_err !== 1'b0)   begin errors++; $display("FAIL w0_store_err got=%b exp=0", z_rsp_err); end
        z_rsp_ready = 1'b1;
        @(posedge clk);
        #1 z_rsp_ready = 1'b0;
        @(negedge clk);
        checks += 2;
        if (z_tohost_valid !== 1'b1) begin errors++; $display("FAIL w0_tohost_valid got=%b exp=1", z_tohost_valid); end
        if (z_tohost_data !== 32'd9) begin errors++; $display("FAIL w0_tohost_data got=%h exp=9", z_tohost_data); end
        z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h64; z_req_be = 4'h0;
        @(posedge clk);
        #1 z_req_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (z_rsp_valid !== 1'b1)   begin errors++; $display("FAIL w0_load_latency got=%b exp=1", z_rsp_valid); end
        if (z_rsp_rdata !== 32'd9)  begin errors++; $display("FAIL w0_load_data got=%h exp=9", z_rsp_rdata); end
        z_rsp_ready = 1'b1;
        @(posedge clk);
        #1 z_rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tohost();
        test_byte_enables();
        test_errors();
        test_hold();
        test_back_to_back();
        test_reset_midflight();
        test_wait0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
